// File: rtl/mem_arb_pkg.sv
// rtl/mem_arb_pkg.sv - shared encodings and defaults for the IF/MEM memory port arbiter
package mem_arb_pkg;

    localparam int AW_DEFAULT           = 32;
    localparam int DW_DEFAULT           = 32;
    localparam int MAX_D_STREAK_DEFAULT = 4;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        IBUSY = 2'd1,
        DBUSY = 2'd2
    } arb_state_t;

    typedef enum logic [1:0] {
        GRANT_NONE = 2'd0,
        GRANT_I    = 2'd1,
        GRANT_D    = 2'd2
    } grant_t;

endpackage

// File: rtl/arb_pick.sv
// rtl/arb_pick.sv - grant decision between fetch and data requesters
module arb_pick
    import mem_arb_pkg::*;
(
    input  logic   if_pend,
    input  logic   d_pend,
    input  logic   if_flush,
    input  logic   streak_max,
    output grant_t grant
);

    // Data wins unless fetch has already waited out a full streak of data grants.
    always_comb begin
        grant = GRANT_NONE;
        if (d_pend && !(if_pend && streak_max))
            grant = GRANT_D;
        else if (if_pend && !if_flush)
            grant = GRANT_I;
    end

endmodule

// File: rtl/mem_port_arbiter.sv
// rtl/mem_port_arbiter.sv - shares one variable-latency memory port between fetch and load/store
module mem_port_arbiter
    import mem_arb_pkg::*;
#(
    parameter int AW           = AW_DEFAULT,
    parameter int DW           = DW_DEFAULT,
    parameter int MAX_D_STREAK = MAX_D_STREAK_DEFAULT
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          if_req,
    input  logic [AW-1:0] if_addr,
    input  logic          if_flush,
    output logic          if_ack,
    output logic [DW-1:0] if_rdata,
    input  logic          dm_rd,
    input  logic          dm_wr,
    input  logic [AW-1:0] dm_addr,
    input  logic [DW-1:0] dm_wdata,
    output logic          dm_ack,
    output logic [DW-1:0] dm_rdata,
    output logic          stall_if,
    output logic          stall_mem,
    output logic          mem_req,
    output logic          mem_we,
    output logic [AW-1:0] mem_addr,
    output logic [DW-1:0] mem_wdata,
    input  logic          mem_ready,
    input  logic [DW-1:0] mem_rdata
);

    localparam int SW = $clog2(MAX_D_STREAK + 1);

    arb_state_t    state;
    logic [SW-1:0] d_streak;
    logic          kill;
    logic          if_pend;
    logic          d_pend;
    logic          streak_max;
    grant_t        grant;

    // A requester whose ack is high is still presenting the request just served.
    assign if_pend    = if_req & ~if_ack;
    assign d_pend     = (dm_rd | dm_wr) & ~dm_ack;
    assign streak_max = (d_streak == SW'(MAX_D_STREAK));
    assign stall_if   = if_pend;
    assign stall_mem  = d_pend;

    arb_pick u_pick (
        .if_pend    (if_pend),
        .d_pend     (d_pend),
        .if_flush   (if_flush),
        .streak_max (streak_max),
        .grant      (grant)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            d_streak  <= '0;
            kill      <= 1'b0;
            mem_req   <= 1'b0;
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            if_ack    <= 1'b0;
            dm_ack    <= 1'b0;
            if_rdata  <= '0;
            dm_rdata  <= '0;
        end else begin
            if_ack <= 1'b0;
            dm_ack <= 1'b0;
            case (state)
                IDLE: begin
                    if (grant == GRANT_D) begin
                        state     <= DBUSY;
                        mem_req   <= 1'b1;
                        mem_we    <= dm_wr;
                        mem_addr  <= dm_addr;
                        mem_wdata <= dm_wdata;
                    end else if (grant == GRANT_I) begin
                        state    <= IBUSY;
                        mem_req  <= 1'b1;
                        mem_we   <= 1'b0;
                        mem_addr <= if_addr;
                    end
                end
                IBUSY: begin
                    if (mem_ready) begin
                        state   <= IDLE;
                        mem_req <= 1'b0;
                        kill    <= 1'b0;
                        // A flush arriving with mem_ready still discards the word.
                        if (!kill && !if_flush) begin
                            if_ack   <= 1'b1;
                            if_rdata <= mem_rdata;
                        end
                    end else if (if_flush) begin
                        kill <= 1'b1;
                    end
                end
                DBUSY: begin
                    if (mem_ready) begin
                        state   <= IDLE;
                        mem_req <= 1'b0;
                        dm_ack  <= 1'b1;
                        if (!mem_we)
                            dm_rdata <= mem_rdata;
                    end
                end
                default: state <= IDLE;
            endcase

            if (!if_req || (state == IDLE && grant == GRANT_I))
                d_streak <= '0;
            else if (state == IDLE && grant == GRANT_D && if_pend && !streak_max)
                d_streak <= d_streak + SW'(1);
        end
    end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb/tb_mem_port_arbiter.sv - self-checking bench for mem_port_arbiter
module tb_mem_port_arbiter;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        if_req = 1'b0;
    logic [31:0] if_addr = '0;
    logic        if_flush = 1'b0;
    logic        if_ack;
    logic [31:0] if_rdata;
    logic        dm_rd = 1'b0;
    logic        dm_wr = 1'b0;
    logic [31:0] dm_addr = '0;
    logic [31:0] dm_wdata = '0;
    logic        dm_ack;
    logic [31:0] dm_rdata;
    logic        stall_if;
    logic        stall_mem;
    logic        mem_req;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic        mem_ready = 1'b0;
    logic [31:0] mem_rdata = '0;

    int n_checks = 0;
    int n_fail   = 0;

    mem_port_arbiter dut (
        .clk       (clk),
        .rst       (rst),
        .if_req    (if_req),
        .if_addr   (if_addr),
        .if_flush  (if_flush),
        .if_ack    (if_ack),
        .if_rdata  (if_rdata),
        .dm_rd     (dm_rd),
        .dm_wr     (dm_wr),
        .dm_addr   (dm_addr),
        .dm_wdata  (dm_wdata),
        .dm_ack    (dm_ack),
        .dm_rdata  (dm_rdata),
        .stall_if  (stall_if),
        .stall_mem (stall_mem),
        .mem_req   (mem_req),
        .mem_we    (mem_we),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_ready (mem_ready),
        .mem_rdata (mem_rdata)
    );

    always #5 clk = ~clk;

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    typedef struct {
        logic         ifr;
        logic [31:0]  ifa;
        logic         fl;
        logic         rd;
        logic         wr;
        logic [31:0]  dma;
        logic         rdy;
        logic [31:0]  rdt;
        logic [133:0] exp;
    } vec_t;

    // Reference model state: one outstanding access at most, owned by nobody, fetch or data.
    localparam int OWN_NONE = 0, OWN_I = 1, OWN_D = 2, MAXS = 4;
    typedef struct {
        int          owner;
        logic        req;
        logic        we;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic        if_ack;
        logic        dm_ack;
        logic [31:0] if_rdata;
        logic [31:0] dm_rdata;
        logic        killed;
        int          waits;
    } mstate_t;

    mstate_t m, n;

    function automatic vec_t mk(input logic ifr, input logic [31:0] ifa, input logic fl,
                                input logic rd, input logic wr, input logic [31:0] dma,
                                input logic rdy, input logic [31:0] rdt,
                                input logic ereq, input logic ewe, input logic [31:0] eaddr,
                                input logic [31:0] ewd, input logic eia, input logic eda,
                                input logic [31:0] eird, input logic [31:0] edrd,
                                input logic esi, input logic esm);
        vec_t v;
        v.ifr = ifr; v.ifa = ifa; v.fl = fl; v.rd = rd; v.wr = wr; v.dma = dma;
        v.rdy = rdy; v.rdt = rdt;
        v.exp = {ereq, ewe, eaddr, ewd, eia, eda, eird, edrd, esi, esm};
        return v;
    endfunction

    function automatic logic [133:0] outs();
        return {mem_req, mem_we, mem_addr, mem_wdata, if_ack, dm_ack,
                if_rdata, dm_rdata, stall_if, stall_mem};
    endfunction

    task automatic chk(input string nm, input logic [133:0] act, input logic [133:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic mstate_t model_step(input mstate_t s);
        mstate_t t = s;
        logic ip = if_req & ~s.if_ack;
        logic dp = (dm_rd | dm_wr) & ~s.dm_ack;
        t.if_ack = 1'b0;
        t.dm_ack = 1'b0;
        if (s.owner == OWN_NONE) begin
            if (dp && !(ip && s.waits == MAXS)) begin
                t.owner = OWN_D; t.req = 1'b1; t.we = dm_wr;
                t.addr = dm_addr; t.wdata = dm_wdata;
                if (ip && s.waits < MAXS) t.waits = s.waits + 1;
            end else if (ip && !if_flush) begin
                t.owner = OWN_I; t.req = 1'b1; t.we = 1'b0;
                t.addr = if_addr; t.waits = 0;
            end
        end else if (mem_ready) begin
            t.owner = OWN_NONE; t.req = 1'b0; t.killed = 1'b0;
            if (s.owner == OWN_D) begin
                t.dm_ack = 1'b1;
                if (!s.we) t.dm_rdata = mem_rdata;
            end else if (!s.killed && !if_flush) begin
                t.if_ack = 1'b1;
                t.if_rdata = mem_rdata;
            end
        end else if (s.owner == OWN_I && if_flush) begin
            t.killed = 1'b1;
        end
        if (!if_req) t.waits = 0;
        return t;
    endfunction

    vec_t vt[24];

    localparam logic [31:0] C  = 32'hCAFE0010;
    localparam logic [31:0] A  = 32'hA5A50080;
    localparam logic [31:0] B  = 32'h11110020;
    localparam logic [31:0] D  = 32'hDEADBEEF;
    localparam logic [31:0] G  = 32'h600D0034;

    initial begin
        int d_grants, i_grants, got_addr, waited;
        logic prev_req, seen_ack, seen;

        vt[0]  = mk(1,'h10,0,0,0,0,    0,0,            0,0,'h10*0,0,0,0,0,0,1,0);
        vt[1]  = mk(1,'h10,0,0,0,0,    0,0,            1,0,'h10,0,0,0,0,0,1,0);
        vt[2]  = mk(1,'h10,0,0,0,0,    0,0,            1,0,'h10,0,0,0,0,0,1,0);
        vt[3]  = mk(1,'h10,0,0,0,0,    1,C,            1,0,'h10,0,0,0,0,0,1,0);
        vt[4]  = mk(1,'h10,0,0,0,0,    0,0,            0,0,'h10,0,1,0,C,0,0,0);
        vt[5]  = mk(0,'h10,0,0,0,0,    1,'h77777777,   0,0,'h10,0,0,0,C,0,0,0);
        vt[6]  = mk(0,0,0,1,1,'h40,    0,0,            0,0,'h10,0,0,0,C,0,0,1);
        vt[7]  = mk(0,0,0,1,1,'h40,    1,'h12345678,   1,1,'h40,D,0,0,C,0,0,1);
        vt[8]  = mk(0,0,0,1,1,'h40,    0,0,            0,1,'h40,D,0,1,C,0,0,0);
        vt[9]  = mk(0,0,0,0,0,0,       0,0,            0,1,'h40,D,0,0,C,0,0,0);
        vt[10] = mk(1,'h20,0,1,0,'h80, 0,0,            0,1,'h40,D,0,0,C,0,1,1);
        vt[11] = mk(1,'h20,0,1,0,'h80, 1,A,            1,0,'h80,D,0,0,C,0,1,1);
        vt[12] = mk(1,'h20,0,1,0,'h80, 0,0,            0,0,'h80,D,0,1,C,A,1,0);
        vt[13] = mk(1,'h20,0,0,0,0,    0,0,            1,0,'h20,D,0,0,C,A,1,0);
        vt[14] = mk(1,'h20,0,0,0,0,    1,B,            1,0,'h20,D,0,0,C,A,1,0);
        vt[15] = mk(1,'h20,0,0,0,0,    0,0,            0,0,'h20,D,1,0,B,A,0,0);
        vt[16] = mk(0,0,0,0,0,0,       0,0,            0,0,'h20,D,0,0,B,A,0,0);
        vt[17] = mk(1,'h30,0,0,0,0,    0,0,            0,0,'h20,D,0,0,B,A,1,0);
        vt[18] = mk(1,'h30,1,0,0,0,    0,0,            1,0,'h30,D,0,0,B,A,1,0);
        vt[19] = mk(1,'h34,0,0,0,0,    1,'hBAD00030,   1,0,'h30,D,0,0,B,A,1,0);
        vt[20] = mk(1,'h34,0,0,0,0,    0,0,            0,0,'h30,D,0,0,B,A,1,0);
        vt[21] = mk(1,'h34,0,0,0,0,    1,G,            1,0,'h34,D,0,0,B,A,1,0);
        vt[22] = mk(1,'h34,0,0,0,0,    0,0,            0,0,'h34,D,1,0,G,A,0,0);
        vt[23] = mk(0,0,0,0,0,0,       0,0,            0,0,'h34,D,0,0,G,A,0,0);

        repeat (2) @(negedge clk);
        chk("reset_outputs", outs(), '0);
        rst = 1'b0;
        dm_wdata = D;

        for (int i = 0; i < 24; i++) begin
            tick();
            if_req = vt[i].ifr; if_addr = vt[i].ifa; if_flush = vt[i].fl;
            dm_rd = vt[i].rd; dm_wr = vt[i].wr; dm_addr = vt[i].dma;
            mem_ready = vt[i].rdy; mem_rdata = vt[i].rdt;
            @(negedge clk);
            chk($sformatf("vec%0d", i), outs(), vt[i].exp);
        end

        // Streak limit: flush keeps fetch from winning in the data ack cycles.
        if_req = 1; if_addr = 'h100; if_flush = 1; dm_rd = 1; dm_wr = 0; dm_addr = 'h200;
        mem_ready = 0; mem_rdata = '0;
        d_grants = 0; i_grants = 0; prev_req = mem_req;
        repeat (30) begin
            tick();
            mem_ready = mem_req;
            if (mem_req && !prev_req) begin
                if (mem_addr == 'h200) d_grants++;
                else i_grants++;
            end
            prev_req = mem_req;
        end
        chk("streak_d_grants", 134'(d_grants), 134'(4));
        chk("streak_no_i_grant", 134'(i_grants), 134'(0));
        if_flush = 0;
        got_addr = -1;
        for (int c = 0; c < 10 && got_addr < 0; c++) begin
            tick();
            mem_ready = mem_req;
            if (mem_req && !prev_req) got_addr = int'(mem_addr);
            prev_req = mem_req;
        end
        chk("streak_then_i_grant", 134'(got_addr), 134'('h100));
        chk("streak_cleared", 134'(dut.d_streak), 134'(0));
        seen_ack = 0;
        for (int c = 0; c < 10 && !seen_ack; c++) begin
            tick();
            mem_ready = mem_req;
            seen_ack = if_ack;
        end
        chk("streak_if_ack", 134'(seen_ack), 134'(1));
        if_req = 0; dm_rd = 0;
        repeat (6) begin tick(); mem_ready = mem_req; end
        mem_ready = 0;

        // Reset in the middle of a data write with memory still busy.
        dm_wr = 1; dm_addr = 'h300; dm_wdata = 'h1;
        waited = 0;
        while (!mem_req && waited < 5) begin tick(); waited++; end
        chk("mid_dbusy_req", 134'(mem_req), 134'(1));
        #2 rst = 1'b1;
        #1;
        chk("rst_async_drop", {132'(0), mem_req, dm_ack}, '0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        tick();
        chk("rst_regrant", {131'(0), mem_req, mem_we, dm_ack},
            {131'(0), 1'b1, 1'b1, 1'b0});
        chk("rst_regrant_addr", 134'(mem_addr), 134'('h300));
        mem_ready = 1;
        tick();
        mem_ready = 0;
        chk("rst_regrant_ack", 134'(dm_ack), 134'(1));
        dm_wr = 0;
        repeat (3) tick();

        // Randomised traffic against the transaction-level model.
        @(negedge clk);
        rst = 1'b1;
        if_req = 0; if_flush = 0; dm_rd = 0; dm_wr = 0; mem_ready = 0;
        @(negedge clk);
        rst = 1'b0;
        m = '{OWN_NONE, 1'b0, 1'b0, '0, '0, 1'b0, 1'b0, '0, '0, 1'b0, 0};
        n = m;
        for (int cyc = 0; cyc < 2000; cyc++) begin
            tick();
            m = n;
            if_flush = 1'b0;
            if (!if_req) begin
                if ($urandom % 2 == 0) begin if_req = 1; if_addr = $urandom; end
            end else if (m.if_ack) begin
                if_req = $urandom % 2;
                if_addr = $urandom;
            end else if ($urandom % 10 == 0) begin
                if_flush = 1'b1;
                if_addr = $urandom;
            end
            seen = dm_rd | dm_wr;
            if ((!seen && $urandom % 3 == 0) || (seen && m.dm_ack)) begin
                dm_rd = $urandom % 2; dm_wr = $urandom % 2;
                dm_addr = $urandom; dm_wdata = $urandom;
            end
            mem_ready = m.req ? ($urandom % 3 == 0) : ($urandom % 8 == 0);
            mem_rdata = $urandom;
            @(negedge clk);
            chk($sformatf("rand%0d", cyc), outs(),
                {m.req, m.we, m.addr, m.wdata, m.if_ack, m.dm_ack, m.if_rdata, m.dm_rdata,
                 if_req & ~m.if_ack, (dm_rd | dm_wr) & ~m.dm_ack});
            n = model_step(m);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
